// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable tick/timeout source.
// A prescaler divides clk. Each prescaler wrap is one tick, and each tick advances
// the main period counter. An expiry raises a sticky irq and can also flag overrun.
// A configuration write made while the timer runs is parked in pend_* registers.
// It is applied only at start, at restart, or at expiry, so a period never changes
// part-way through.
module timer_ctrl #(
    parameter int COUNT_WIDTH    = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [COUNT_WIDTH-1:0]    cfg_period,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_periodic,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      irq_ack,
    output logic                      busy,
    output logic                      tick,
    output logic                      irq,
    output logic                      overrun,
    output logic [COUNT_WIDTH-1:0]    count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_reg;
    logic [PRESCALE_WIDTH-1:0] presc_reg;
    logic [COUNT_WIDTH-1:0]    count_reg;
    logic                      irq_reg;
    logic                      overrun_reg;

    // Operating copies of the configuration.
    logic [COUNT_WIDTH-1:0]    period_sh;
    logic [PRESCALE_WIDTH-1:0] prescale_sh;
    logic                      periodic_sh;

    // Writes that arrive while running wait here until the next safe point.
    logic [COUNT_WIDTH-1:0]    pend_period;
    logic [PRESCALE_WIDTH-1:0] pend_prescale;
    logic                      pend_periodic;
    logic                      pend_valid;

    logic tick_hit;
    logic at_period;
    logic expire;

    // Tick is the prescaler reaching its terminal value while running.
    // Expiry is a tick on the last count. A stop or a start in the same cycle suppresses it.
    always_comb begin
        tick_hit  = (state_reg == RUN) && (presc_reg == prescale_sh);
        at_period = (count_reg == period_sh);
        expire    = tick_hit && at_period && !stop && !start;
    end

    assign busy    = (state_reg == RUN);
    assign tick    = tick_hit;
    assign irq     = irq_reg;
    assign overrun = overrun_reg;
    assign count   = count_reg;

    // Controller state, both counters, the configuration registers and the interrupt flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            count_reg     <= '0;
            irq_reg       <= 1'b0;
            overrun_reg   <= 1'b0;
            period_sh     <= '0;
            prescale_sh   <= '0;
            periodic_sh   <= 1'b0;
            pend_period   <= '0;
            pend_prescale <= '0;
            pend_periodic <= 1'b0;
            pend_valid    <= 1'b0;
        end else begin
            // If an expiry coincides with an ack, the expiry wins. Overrun is then left as it was.
            if (expire) begin
                irq_reg <= 1'b1;
            end else if (irq_ack) begin
                irq_reg <= 1'b0;
            end
            if (expire && irq_reg && !irq_ack) begin
                overrun_reg <= 1'b1;
            end else if (irq_ack && !expire) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        state_reg <= RUN;
                        presc_reg <= '0;
                        count_reg <= '0;
                        if (pend_valid) begin
                            period_sh   <= pend_period;
                            prescale_sh <= pend_prescale;
                            periodic_sh <= pend_periodic;
                            pend_valid  <= 1'b0;
                        end
                    end
                    // A direct write is newer than anything still pending, so it overrides the pending values.
                    if (cfg_we) begin
                        period_sh   <= cfg_period;
                        prescale_sh <= cfg_prescale;
                        periodic_sh <= cfg_periodic;
                        pend_valid  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                    end else if (start) begin
                        presc_reg <= '0;
                        count_reg <= '0;
                        if (pend_valid) begin
                            period_sh   <= pend_period;
                            prescale_sh <= pend_prescale;
                            periodic_sh <= pend_periodic;
                            pend_valid  <= 1'b0;
                        end
                    end else if (tick_hit) begin
                        presc_reg <= '0;
                        if (at_period) begin
                            count_reg <= '0;
                            if (pend_valid) begin
                                period_sh   <= pend_period;
                                prescale_sh <= pend_prescale;
                                periodic_sh <= pend_periodic;
                                pend_valid  <= 1'b0;
                            end
                            if (!periodic_sh) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            count_reg <= count_reg + COUNT_WIDTH'(1);
                        end
                    end else begin
                        presc_reg <= presc_reg + PRESCALE_WIDTH'(1);
                    end
                    // A write in the same cycle as an apply stays pending for the next safe point.
                    if (cfg_we) begin
                        pend_period   <= cfg_period;
                        pend_prescale <= cfg_prescale;
                        pend_periodic <= cfg_periodic;
                        pend_valid    <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl.
// Inputs change 1ns after each rising edge. Outputs are checked at that same point.
module tb_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_prescale;
    logic        cfg_periodic;
    logic        start;
    logic        stop;
    logic        irq_ack;
    logic        busy;
    logic        tick;
    logic        irq;
    logic        overrun;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(
        .COUNT_WIDTH   (16),
        .PRESCALE_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_period  (cfg_period),
        .cfg_prescale(cfg_prescale),
        .cfg_periodic(cfg_periodic),
        .start       (start),
        .stop        (stop),
        .irq_ack     (irq_ack),
        .busy        (busy),
        .tick        (tick),
        .irq         (irq),
        .overrun     (overrun),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [15:0] p, input logic [7:0] s, input logic per);
        cfg_we = 1'b1;
        cfg_period = p;
        cfg_prescale = s;
        cfg_periodic = per;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cfg_we = 1'b0;
        cfg_period = '0;
        cfg_prescale = '0;
        cfg_periodic = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        irq_ack = 1'b0;

        // Reset held for 3 cycles while start and cfg_we toggle.
        for (int i = 0; i < 3; i++) begin
            start = i[0];
            cfg_we = ~i[0];
            cyc();
            check($sformatf("rst_busy%0d", i), busy, 0);
            check($sformatf("rst_irq%0d", i), irq, 0);
            check($sformatf("rst_ovr%0d", i), overrun, 0);
            check($sformatf("rst_cnt%0d", i), count, 0);
            check($sformatf("rst_tick%0d", i), tick, 0);
        end
        start = 1'b0;
        cfg_we = 1'b0;
        reset = 1'b1;
        cyc();

        // One-shot, P=3 S=1: expires 8 cycles after start.
        write_cfg(16'd3, 8'd1, 1'b0);
        pulse_start();
        check("os_busy0", busy, 1);
        check("os_cnt0", count, 0);
        check("os_tick0", tick, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k < 8) begin
                check($sformatf("os_cnt%0d", k), count, k / 2);
                check($sformatf("os_tick%0d", k), tick, k % 2);
                check($sformatf("os_irq%0d", k), irq, 0);
                check($sformatf("os_busy%0d", k), busy, 1);
            end else begin
                check("os_irq_done", irq, 1);
                check("os_busy_done", busy, 0);
                check("os_cnt_done", count, 0);
            end
        end
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        check("os_ack_irq", irq, 0);

        // Periodic, P=2 S=0: expiries at 3, 6, 9. Ack at edge 9 (same as the expiry), then again at edge 10.
        write_cfg(16'd2, 8'd0, 1'b1);
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            irq_ack = (k == 9 || k == 10);
            cyc();
            check($sformatf("pr_cnt%0d", k), count, k % 3);
            check($sformatf("pr_irq%0d", k), irq, (k >= 3 && k <= 9) ? 1 : 0);
            check($sformatf("pr_ovr%0d", k), overrun, (k >= 6 && k <= 9) ? 1 : 0);
        end
        irq_ack = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pr_stop_busy", busy, 0);
        check("pr_stop_cnt", count, 1);

        // Deferred config: P=4, then a write of P=1 while running at edge 2. Acks at edges 6 and 8.
        write_cfg(16'd4, 8'd0, 1'b1);
        pulse_start();
        begin
            logic [15:0] exp_cnt [1:9];
            logic        exp_irq [1:9];
            exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
            exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int k = 1; k <= 9; k++) begin
                cfg_we = (k == 2);
                cfg_period = 16'd1;
                cfg_prescale = 8'd0;
                cfg_periodic = 1'b1;
                irq_ack = (k == 6 || k == 8);
                cyc();
                check($sformatf("df_cnt%0d", k), count, exp_cnt[k]);
                check($sformatf("df_irq%0d", k), irq, exp_irq[k]);
                check($sformatf("df_ovr%0d", k), overrun, 0);
            end
        end
        cfg_we = 1'b0;
        stop = 1'b1;
        irq_ack = 1'b1;
        cyc();
        stop = 1'b0;
        irq_ack = 1'b0;
        check("df_stop_irq", irq, 0);

        // Priority: start and stop together with count=2 go to IDLE, and count holds.
        write_cfg(16'd4, 8'd0, 1'b1);
        pulse_start();
        cyc();
        cyc();
        check("ss_cnt_pre", count, 2);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy", busy, 0);
        check("ss_cnt_hold", count, 2);
        check("ss_irq", irq, 0);
        cyc();
        check("ss_cnt_idle", count, 2);
        pulse_start();
        check("ss_rst_busy", busy, 1);
        check("ss_rst_cnt", count, 0);
        cyc();
        check("ss_rst_cnt1", count, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Boundary P=0 S=0: tick is high and an expiry occurs every cycle.
        write_cfg(16'd0, 8'd0, 1'b1);
        pulse_start();
        check("b0_tick0", tick, 1);
        check("b0_irq0", irq, 0);
        cyc();
        check("b0_tick1", tick, 1);
        check("b0_irq1", irq, 1);
        check("b0_cnt1", count, 0);
        check("b0_ovr1", overrun, 0);
        cyc();
        check("b0_ovr2", overrun, 1);
        check("b0_busy2", busy, 1);

        // Asynchronous reset mid-run: outputs clear before the next clock edge.
        reset = 1'b0;
        #1;
        check("ar_irq", irq, 0);
        check("ar_ovr", overrun, 0);
        check("ar_busy", busy, 0);
        check("ar_tick", tick, 0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable timer controller that sequences two internal counters: a prescaler and a main period counter.
- Generates periodic or one-shot expiry events.
- Raises a sticky interrupt with acknowledge handshake and overrun detection.
- Sits beside the core as the system tick/timeout source; its configuration inputs are driven by a bus register slave.

Parameters:
COUNT_WIDTH, 16, width of main counter and period value
PRESCALE_WIDTH, 8, width of prescaler counter and prescale value

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cfg_we  input  1  write strobe for cfg_period/cfg_prescale/cfg_periodic
cfg_period  input  COUNT_WIDTH  main counter terminal value P
cfg_prescale  input  PRESCALE_WIDTH  prescaler terminal value S
cfg_periodic  input  1  1 = periodic mode, 0 = one-shot
start  input  1  single-cycle pulse; start/restart the timer
stop  input  1  single-cycle pulse; halt the timer
irq_ack  input  1  clears irq and overrun
busy  output  1  1 while in RUN
tick  output  1  one-cycle pulse on each prescaler wrap
irq  output  1  sticky expiry interrupt
overrun  output  1  expiry occurred while irq still pending
count  output  COUNT_WIDTH  current main counter value

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Prescaler, count, and all shadow/pending registers = 0.
  - cfg_periodic shadow = 0.
  - busy=0, tick=0, irq=0, overrun=0.
- Shadow registers: period_sh, prescale_sh, periodic_sh drive operation; pend_* registers plus pend_valid hold writes made while running.
- cfg_we in IDLE: loads shadows directly on the next edge.
- cfg_we in RUN: loads pend_* and sets pend_valid. A later write overwrites pend_* (last write wins).
- States:
  - IDLE: counters hold. start -> RUN with prescaler=0 and count=0. If pend_valid, pend_* are copied to shadows and pend_valid cleared on the same edge.
  - RUN: prescaler increments each cycle.
- Tick: tick=1 combinationally when state=RUN and prescaler==prescale_sh. On that edge the prescaler goes to 0.
- Count advance: on a tick edge with count!=period_sh, count increments.
- Expiry (tick edge with count==period_sh):
  - count -> 0 and irq set.
  - If pend_valid: shadows <= pend_*, pend_valid <= 0.
  - periodic_sh=1 (value before any update): stay in RUN.
  - periodic_sh=0: go to IDLE with count=0.
- Expiry period: exactly (P+1)*(S+1) clk cycles after start. P=0, S=0 expires every cycle.
- Priority: stop > start > normal operation.
  - stop in RUN -> IDLE; count and prescaler hold their values, no expiry that cycle.
  - stop in IDLE: no effect.
  - start in RUN (without stop): restart. Prescaler=0, count=0, pending config applied, no expiry that cycle.
- irq: set on expiry; cleared by irq_ack. Expiry and irq_ack in the same cycle leave irq=1 (set wins) and overrun unchanged.
- overrun: set on expiry when irq=1 and irq_ack=0; cleared by irq_ack.
- busy = (state==RUN), registered state, no combinational path from start.
- count output is the registered main counter.
- No arithmetic overflow: count never exceeds period_sh; the prescaler never exceeds prescale_sh. Shadows change only in IDLE, at start, or at expiry.
- Asynchronous reset mid-RUN immediately forces all outputs to their reset values. Operation resumes only on the first clock edge after reset=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles, toggling start/cfg_we -> busy=0, irq=0, overrun=0, count=0, tick=0 throughout.
- One-shot: write P=3, S=1, periodic=0; pulse start -> tick every 2 cycles; irq rises exactly 8 cycles after start; busy falls the same edge; count=0 afterwards.
- Periodic with overrun: P=2, S=0, periodic=1, never ack -> irq at cycles 3, 6, ...; overrun set at cycle 6. irq_ack coincident with the cycle-9 expiry leaves irq=1, overrun=1. Ack one cycle later -> both 0.
- Deferred config: periodic P=4, S=0; write P=1 at cycle 2 -> first expiry still at cycle 5, subsequent expiries every 2 cycles.
- Stop/start priority: in RUN with count=2, assert start and stop together -> IDLE, count holds 2, no irq. Later start alone -> count restarts from 0.
- Boundary P=0, S=0, periodic: tick=1 and an expiry every cycle; count stays 0. Mid-run asynchronous reset -> irq drops without waiting for a clock edge.
